// File: rtl/execute_pipe.sv
// Single-issue execute stage: ALU, branch-target adder, status flags and a
// registered result with valid/ready handshake. Define EXEC_PIPE_MUL_EN to build the multi-cycle shift-add MUL.
module execute_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [3:0]       op,
  input  logic             alu_src,
  input  logic             update_sreg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] branch_target,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] bt;
  logic             c_flag;
  logic             v_flag;
  logic             accept;

  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign bt       = pc + (imm << 2);

  always_comb begin
    opb    = alu_src ? imm : read_data2;
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (op)
      4'b0000: res = read_data1 & opb;
      4'b0001: res = read_data1 | opb;
      4'b0010: begin
        {c_flag, res} = {1'b0, read_data1} + {1'b0, opb};
        v_flag = (read_data1[WIDTH-1] == opb[WIDTH-1]) && (res[WIDTH-1] != read_data1[WIDTH-1]);
      end
      4'b0110: begin
        {c_flag, res} = {1'b0, read_data1} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
        v_flag = (read_data1[WIDTH-1] != opb[WIDTH-1]) && (res[WIDTH-1] != read_data1[WIDTH-1]);
      end
      4'b0111: res = opb;
      4'b1100: res = ~(read_data1 | opb);
      default: res = '0;
    endcase
  end

`ifdef EXEC_PIPE_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mul_bt;
  logic             mul_sreg;
  logic             is_mul;

  assign is_mul   = (op == 4'b1000);
  assign acc_next = mplier[0] ? acc + mcand : acc;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      branch_target <= '0;
      negative      <= 1'b0;
      zero          <= 1'b0;
      carry         <= 1'b0;
      overflow      <= 1'b0;
`ifdef EXEC_PIPE_MUL_EN
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_bt   <= '0;
      mul_sreg <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
`ifdef EXEC_PIPE_MUL_EN
        // MUL holds its branch target and flag-enable until the product lands
        if (is_mul) begin
          state    <= MUL_RUN;
          busy     <= 1'b1;
          cnt      <= '0;
          mcand    <= read_data1;
          mplier   <= opb;
          acc      <= '0;
          mul_bt   <= bt;
          mul_sreg <= update_sreg;
        end else
`endif
        begin
          out_valid     <= 1'b1;
          alu_result    <= res;
          branch_target <= bt;
          if (update_sreg) begin
            negative <= res[WIDTH-1];
            zero     <= (res == '0);
            carry    <= c_flag;
            overflow <= v_flag;
          end
        end
      end
`ifdef EXEC_PIPE_MUL_EN
      if (state == MUL_RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state         <= IDLE;
          busy          <= 1'b0;
          out_valid     <= 1'b1;
          alu_result    <= acc_next;
          branch_target <= mul_bt;
          if (mul_sreg) begin
            negative <= acc_next[WIDTH-1];
            zero     <= (acc_next == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe (WIDTH=64): vector table plus handshake,
// multiply and reset sequences; follows EXEC_PIPE_MUL_EN for the MUL cases.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] pc, imm, read_data1, read_data2;
  logic [3:0]  op;
  logic        alu_src, update_sreg;
  logic        out_valid, out_ready;
  logic [63:0] alu_result, branch_target;
  logic        negative, zero, carry, overflow, busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  execute_pipe #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .read_data1(read_data1), .read_data2(read_data2),
    .op(op), .alu_src(alu_src), .update_sreg(update_sreg),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .branch_target(branch_target),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b, imm, pc;
    logic        src, upd;
    logic [63:0] res, bt;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] im, input logic [63:0] p, input logic s, input logic u);
    op = o; read_data1 = a; read_data2 = b; imm = im; pc = p; alu_src = s; update_sreg = u;
  endtask

  function automatic logic [3:0] flags();
    return {negative, zero, carry, overflow};
  endfunction

  initial begin
    int unsigned busy_cycles, bad, stale;

    vecs[0] = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h1000, 1'b0, 1'b1,
                64'h8000_0000_0000_0000, 64'h1000, 4'b1001};
    vecs[1] = '{4'b0001, 64'h0F0, 64'hF00, 64'h0, 64'h1000, 1'b0, 1'b0,
                64'hFF0, 64'h1000, 4'b1001};
    vecs[2] = '{4'b0110, 64'h5, 64'h0, 64'h5, 64'h1000, 1'b1, 1'b1,
                64'h0, 64'h1014, 4'b0110};
    vecs[3] = '{4'b0000, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h10, 64'h2000, 1'b0, 1'b1,
                64'h0F0F_0000_0F0F_0000, 64'h2040, 4'b0000};
    vecs[4] = '{4'b1100, 64'h0, 64'h0, 64'h0, 64'h1000, 1'b0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h1000, 4'b1000};
    vecs[5] = '{4'b0111, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1000, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFC, 4'b1000};
    vecs[6] = '{4'b0110, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 64'h1000, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 64'h1000, 4'b0011};
    vecs[7] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h1000, 1'b0, 1'b1,
                64'h0, 64'h1000, 4'b0110};
    vecs[8] = '{4'b0011, 64'h55, 64'h66, 64'h0, 64'h1000, 1'b0, 1'b1,
                64'h0, 64'h1000, 4'b0100};
    vecs[9] = '{4'b0010, 64'h2, 64'h3, 64'h0, 64'h1000, 1'b0, 1'b0,
                64'h5, 64'h1000, 4'b0100};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", alu_result, 64'd0);
    chk("rst_bt", branch_target, 64'd0);
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);

    // back-to-back table vectors, one accept per cycle
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, vecs[i].src, vecs[i].upd);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_res", i), alu_result, vecs[i].res);
      chk($sformatf("v%0d_bt", i), branch_target, vecs[i].bt);
      chk($sformatf("v%0d_nzcv", i), 64'(flags()), 64'(vecs[i].nzcv));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // backpressure: result held, nothing accepted, then transfer+accept together
    drive(4'b0010, 64'h2, 64'h3, 64'h0, 64'h1000, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first", alu_result, 64'h5);
    out_ready = 1'b0;
    drive(4'b0001, 64'h1, 64'h2, 64'h0, 64'h1000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
      @(negedge clk);
      chk($sformatf("bp%0d_res", k), alu_result, 64'h5);
      chk($sformatf("bp%0d_valid", k), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_new_res", alu_result, 64'h3);
    chk("bp_new_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);

`ifdef EXEC_PIPE_MUL_EN
    drive(4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0, 64'h1000, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    drive(4'b0010, 64'h2, 64'h3, 64'h0, 64'h1000, 1'b0, 1'b1);
    busy_cycles = 0; bad = 0;
    for (int k = 0; k < 200 && busy; k++) begin
      busy_cycles++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", 64'(busy_cycles), 64'd64);
    chk("mul_stall_violations", 64'(bad), 64'd0);
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_res", alu_result, 64'hFFFF_FFFE_0000_0001);
    chk("mul_bt", branch_target, 64'h1000);
    chk("mul_nzcv", 64'(flags()), 64'b1000);
    @(negedge clk);

    drive(4'b1000, 64'h7, 64'h9, 64'h0, 64'h1000, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
`else
    drive(4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0, 64'h1000, 1'b0, 1'b1);
    in_valid = 1'b1;
    #1 chk("nomul_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("nomul_valid", 64'(out_valid), 64'd1);
    chk("nomul_res", alu_result, 64'h0);
    chk("nomul_nzcv", 64'(flags()), 64'b0100);
    chk("nomul_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
`endif
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res", alu_result, 64'd0);
    chk("arst_bt", branch_target, 64'd0);
    chk("arst_flags", 64'(flags()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("arst_rel_in_ready", 64'(in_ready), 64'd1);
    drive(4'b0010, 64'h2, 64'h3, 64'h0, 64'h1000, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_res", alu_result, 64'h5);
    chk("post_rst_nzcv", 64'(flags()), 64'b0000);
    @(negedge clk);
    stale = 0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid !== 1'b0 || alu_result !== 64'h5) stale++;
      @(negedge clk);
    end
    chk("no_stale_result", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter WIDTH, default 64: datapath width in bits; legal values are 16 to 64 in steps of 8.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand bundle present.
REQ-005 in_ready  output  1  block accepts the bundle this cycle.
REQ-006 pc, imm, read_data1, read_data2  input  WIDTH each  program counter, sign-extended immediate, register operands.
REQ-007 op  input  4  decoded ALU op: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASS_B, 1100 NOR, 1000 MUL.
REQ-008 alu_src  input  1  selects operand B: 0 selects read_data2, 1 selects imm.
REQ-009 update_sreg  input  1  this op writes the status flags.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 alu_result, branch_target  output  WIDTH each  registered results.
REQ-013 negative, zero, carry, overflow  output  1 each  registered status flags.
REQ-014 busy  output  1  multi-cycle op in progress.

Function
REQ-015 A transfer in SHALL occur on an edge where in_valid && in_ready; a transfer out SHALL occur on an edge where out_valid && out_ready.
REQ-016 in_ready SHALL equal !busy && (!out_valid || out_ready), with combinational dependence on out_ready only.
REQ-017 A non-MUL op accepted at edge N SHALL set out_valid and load its results at edge N, so the results are visible in the following cycle; back-to-back accepts sustain one result per cycle.
REQ-018 branch_target SHALL be (pc + (imm << 2)) mod 2^WIDTH, and SHALL be computed for every op.
REQ-019 ADD SHALL produce A+B; carry is the carry out of bit WIDTH-1; overflow is signed overflow.
REQ-020 SUB SHALL be computed as A+~B+1; carry is 1 when there is no borrow; overflow is signed overflow.
REQ-021 AND, ORR, NOR and PASS_B SHALL produce carry=0 and overflow=0; all ops set negative = result[WIDTH-1] and zero = (result==0).
REQ-022 An undefined op SHALL produce result 0 with flags N=0, Z=1, C=0, V=0.
REQ-023 The FSM SHALL have two states, IDLE and MUL_RUN; accepting MUL in IDLE moves to MUL_RUN, raises busy and clears a counter.
REQ-024 MUL_RUN SHALL perform one shift-add step per cycle for WIDTH cycles; on the WIDTH-th step edge it loads the low WIDTH bits of the product, sets out_valid, drops busy and returns to IDLE.
REQ-025 MUL SHALL produce C=0 and V=0.
REQ-026 An op accepted together with the outgoing transfer at the same edge SHALL overwrite the result register; without an accept, out_valid SHALL clear at the transfer edge.
REQ-027 While out_valid && !out_ready, alu_result, branch_target and the flags SHALL hold stable.
REQ-028 The status flags SHALL update only when the result register is loaded by an op with update_sreg=1, and otherwise keep their previous value.
REQ-029 in_valid asserted while busy SHALL be ignored, with no state change.

Reset
REQ-030 On reset low, the block SHALL asynchronously set out_valid=0, busy=0, FSM=IDLE, counter=0, alu_result=0, branch_target=0 and all four flags=0.
REQ-031 Reset asserted during MUL_RUN SHALL abort the multiply, and no result SHALL ever be presented.
REQ-032 After reset release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-033 Macro EXEC_PIPE_MUL_EN: when defined, the MUL datapath, counter and MUL_RUN state SHALL be built as specified.
REQ-034 When EXEC_PIPE_MUL_EN is undefined, op 1000 SHALL be treated as undefined (REQ-022), busy SHALL be tied to 0, and no MUL_RUN state SHALL exist.

Verification (WIDTH=64)
REQ-035 ADD 0x7FFF_FFFF_FFFF_FFFF + 1, update_sreg=1 -> result 0x8000_0000_0000_0000, N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept.
REQ-036 SUB 5 - 5 via alu_src=1, imm=5 -> result 0, Z=1 C=1 N=0 V=0; pc=0x1000, imm=5 -> branch_target 0x1014.
REQ-037 MUL 0xFFFF_FFFF × 0xFFFF_FFFF (EXEC_PIPE_MUL_EN defined) -> busy for 64 cycles, in_ready=0 throughout, result 0xFFFF_FFFE_0000_0001.
REQ-038 out_ready=0 for 3 cycles with in_valid held -> result stable, no accept; out_ready=1 -> transfer and accept on the same edge.
REQ-039 Reset pulled low at cycle 10 of a MUL -> all outputs 0 immediately; after release, ADD 2+3 -> result 5 with no stale MUL result.
REQ-040 ORR with update_sreg=0 after the REQ-035 ADD -> flags stay N=1 V=1; without EXEC_PIPE_MUL_EN, MUL -> result 0, Z=1, busy=0.
